// File: rtl/ula_controlador_pkg.sv
// rtl/ula_controlador_pkg.sv - opcodes, FSM states and opcode check shared by the ALU controller
package ula_controlador_pkg;

  localparam logic [3:0] OP_SOMA  = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MULT  = 4'b0010;
  localparam logic [3:0] OP_QUOC  = 4'b0011;
  localparam logic [3:0] OP_RESTO = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    AGUARDA  = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  function automatic logic op_valido(input logic [3:0] op);
    case (op)
      OP_SOMA, OP_SUB, OP_MULT, OP_QUOC, OP_RESTO,
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_NOT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_controlador.sv
// rtl/ula_controlador.sv - command/result controller that drives the 8-bit ALU and keeps an accumulator
module ula_controlador
  import ula_controlador_pkg::*;
#(
  parameter int LATENCIA  = 1,
  parameter int LARG_CONT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [7:0]           cmd_a,
  input  logic [7:0]           cmd_b,
  input  logic                 cmd_usa_acc,
  output logic [7:0]           ula_a,
  output logic [7:0]           ula_b,
  output logic [3:0]           ula_sel,
  input  logic [15:0]          ula_res,
  input  logic                 ula_maior,
  input  logic                 ula_menor,
  input  logic                 ula_igual,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_dado,
  output logic [2:0]           res_flags,
  output logic                 res_erro,
  output logic [7:0]           acc,
  output logic [LARG_CONT-1:0] num_ops
);

  localparam logic [3:0] CONT_INI = 4'(LATENCIA - 1);

  estado_t              estado_q, estado_d;
  logic [3:0]           cont_q, cont_d;
  logic [7:0]           ula_a_q, ula_a_d;
  logic [7:0]           ula_b_q, ula_b_d;
  logic [3:0]           ula_sel_q, ula_sel_d;
  logic [15:0]          res_dado_q, res_dado_d;
  logic [2:0]           res_flags_q, res_flags_d;
  logic                 res_erro_q, res_erro_d;
  logic [7:0]           acc_q, acc_d;
  logic [LARG_CONT-1:0] num_ops_q, num_ops_d;
  logic [7:0]           op_a;

  always_comb begin
    estado_d    = estado_q;
    cont_d      = cont_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_sel_d   = ula_sel_q;
    res_dado_d  = res_dado_q;
    res_flags_d = res_flags_q;
    res_erro_d  = res_erro_q;
    acc_d       = acc_q;
    num_ops_d   = num_ops_q;
    op_a        = cmd_usa_acc ? acc_q : cmd_a;

    case (estado_q)
      OCIOSO: begin
        if (cmd_valid) begin
          // Rejected commands answer immediately and leave the ALU inputs untouched.
          if (!op_valido(cmd_op)) begin
            res_dado_d  = 16'h0000;
            res_flags_d = 3'b000;
            res_erro_d  = 1'b1;
            estado_d    = RESPOSTA;
          end else if ((cmd_op == OP_QUOC || cmd_op == OP_RESTO) && cmd_b == 8'd0) begin
            res_dado_d  = 16'hFFFF;
            res_flags_d = 3'b000;
            res_erro_d  = 1'b1;
            estado_d    = RESPOSTA;
          end else begin
            ula_a_d   = op_a;
            ula_b_d   = cmd_b;
            ula_sel_d = cmd_op;
            cont_d    = CONT_INI;
            estado_d  = AGUARDA;
          end
        end
      end
      AGUARDA: begin
        if (cont_q == 4'd0) begin
          res_dado_d  = ula_res;
          res_flags_d = {ula_maior, ula_menor, ula_igual};
          res_erro_d  = 1'b0;
          acc_d       = ula_res[7:0];
          estado_d    = RESPOSTA;
        end else begin
          cont_d = cont_q - 4'd1;
        end
      end
      RESPOSTA: begin
        if (res_ready) begin
          num_ops_d = num_ops_q + LARG_CONT'(1);
          estado_d  = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      cont_q      <= 4'd0;
      ula_a_q     <= 8'd0;
      ula_b_q     <= 8'd0;
      ula_sel_q   <= 4'd0;
      res_dado_q  <= 16'd0;
      res_flags_q <= 3'd0;
      res_erro_q  <= 1'b0;
      acc_q       <= 8'd0;
      num_ops_q   <= '0;
    end else begin
      estado_q    <= estado_d;
      cont_q      <= cont_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_sel_q   <= ula_sel_d;
      res_dado_q  <= res_dado_d;
      res_flags_q <= res_flags_d;
      res_erro_q  <= res_erro_d;
      acc_q       <= acc_d;
      num_ops_q   <= num_ops_d;
    end
  end

  assign cmd_ready = (estado_q == OCIOSO);
  assign res_valid = (estado_q == RESPOSTA);
  assign ula_a     = ula_a_q;
  assign ula_b     = ula_b_q;
  assign ula_sel   = ula_sel_q;
  assign res_dado  = res_dado_q;
  assign res_flags = res_flags_q;
  assign res_erro  = res_erro_q;
  assign acc       = acc_q;
  assign num_ops   = num_ops_q;

endmodule

// File: tb/tb_ula_controlador.sv
// tb/tb_ula_controlador.sv - directed bench for ula_controlador with a behavioural ALU peer
module tb_ula_controlador;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [18:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [15:0] r;
    case (sel)
      4'b0000: r = 16'(a) + 16'(b);
      4'b0001: r = 16'(a) - 16'(b);
      4'b0010: r = 16'(a) * 16'(b);
      4'b0011: r = (b == 8'd0) ? 16'hFFFF : 16'(a / b);
      4'b0100: r = (b == 8'd0) ? 16'hFFFF : 16'(a % b);
      4'b0110: r = {8'h00, a & b};
      4'b0111: r = {8'h00, a | b};
      4'b1000: r = {8'h00, ~(a & b)};
      4'b1001: r = {8'h00, ~(a | b)};
      4'b1010: r = {8'h00, a ^ b};
      4'b1011: r = {8'h00, ~a};
      default: r = 16'h0000;
    endcase
    return {r, a > b, a < b, a == b};
  endfunction

  // Instance A: LATENCIA=1, 4-bit counter
  logic        a_cmd_valid, a_cmd_usa_acc, a_res_ready;
  logic [3:0]  a_cmd_op;
  logic [7:0]  a_cmd_a, a_cmd_b;
  logic        a_cmd_ready, a_res_valid, a_res_erro;
  logic [7:0]  a_ula_a, a_ula_b, a_acc;
  logic [3:0]  a_ula_sel, a_num_ops;
  logic [15:0] a_res_dado;
  logic [2:0]  a_res_flags;
  logic [18:0] a_alu;
  assign a_alu = alu(a_ula_a, a_ula_b, a_ula_sel);

  ula_controlador #(.LATENCIA(1), .LARG_CONT(4)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
    .cmd_a(a_cmd_a), .cmd_b(a_cmd_b), .cmd_usa_acc(a_cmd_usa_acc),
    .ula_a(a_ula_a), .ula_b(a_ula_b), .ula_sel(a_ula_sel),
    .ula_res(a_alu[18:3]), .ula_maior(a_alu[2]), .ula_menor(a_alu[1]), .ula_igual(a_alu[0]),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_dado(a_res_dado),
    .res_flags(a_res_flags), .res_erro(a_res_erro), .acc(a_acc), .num_ops(a_num_ops)
  );

  // Instances B (LATENCIA=3) and C (LATENCIA=4) share one stimulus set
  logic        bc_cmd_valid, bc_cmd_usa_acc, bc_res_ready;
  logic [3:0]  bc_cmd_op;
  logic [7:0]  bc_cmd_a, bc_cmd_b;
  logic        b_cmd_ready, b_res_valid, b_res_erro, c_cmd_ready, c_res_valid, c_res_erro;
  logic [7:0]  b_ula_a, b_ula_b, b_acc, c_ula_a, c_ula_b, c_acc;
  logic [3:0]  b_ula_sel, c_ula_sel;
  logic [15:0] b_res_dado, c_res_dado, b_num_ops, c_num_ops;
  logic [2:0]  b_res_flags, c_res_flags;
  logic [18:0] b_alu, c_alu;
  assign b_alu = alu(b_ula_a, b_ula_b, b_ula_sel);
  assign c_alu = alu(c_ula_a, c_ula_b, c_ula_sel);

  ula_controlador #(.LATENCIA(3), .LARG_CONT(16)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(bc_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(bc_cmd_op),
    .cmd_a(bc_cmd_a), .cmd_b(bc_cmd_b), .cmd_usa_acc(bc_cmd_usa_acc),
    .ula_a(b_ula_a), .ula_b(b_ula_b), .ula_sel(b_ula_sel),
    .ula_res(b_alu[18:3]), .ula_maior(b_alu[2]), .ula_menor(b_alu[1]), .ula_igual(b_alu[0]),
    .res_valid(b_res_valid), .res_ready(bc_res_ready), .res_dado(b_res_dado),
    .res_flags(b_res_flags), .res_erro(b_res_erro), .acc(b_acc), .num_ops(b_num_ops)
  );

  ula_controlador #(.LATENCIA(4), .LARG_CONT(16)) dut_c (
    .clk(clk), .rst(rst),
    .cmd_valid(bc_cmd_valid), .cmd_ready(c_cmd_ready), .cmd_op(bc_cmd_op),
    .cmd_a(bc_cmd_a), .cmd_b(bc_cmd_b), .cmd_usa_acc(bc_cmd_usa_acc),
    .ula_a(c_ula_a), .ula_b(c_ula_b), .ula_sel(c_ula_sel),
    .ula_res(c_alu[18:3]), .ula_maior(c_alu[2]), .ula_menor(c_alu[1]), .ula_igual(c_alu[0]),
    .res_valid(c_res_valid), .res_ready(bc_res_ready), .res_dado(c_res_dado),
    .res_flags(c_res_flags), .res_erro(c_res_erro), .acc(c_acc), .num_ops(c_num_ops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge, then scrambles cmd_* to prove they are not re-sampled.
  task automatic send_a(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic usa);
    a_cmd_op = op; a_cmd_a = a; a_cmd_b = b; a_cmd_usa_acc = usa; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0; a_cmd_op = 4'hF; a_cmd_a = 8'hEE; a_cmd_b = 8'hEE; a_cmd_usa_acc = 1'b0;
  endtask

  task automatic handshake_a();
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
  endtask

  initial begin
    a_cmd_valid = 0; a_cmd_usa_acc = 0; a_res_ready = 0; a_cmd_op = 0; a_cmd_a = 0; a_cmd_b = 0;
    bc_cmd_valid = 0; bc_cmd_usa_acc = 0; bc_res_ready = 0; bc_cmd_op = 0; bc_cmd_a = 0; bc_cmd_b = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_cmd_ready", 32'(a_cmd_ready), 1);
    chk("rst_res_valid", 32'(a_res_valid), 0);
    chk("rst_acc", 32'(a_acc), 0);
    chk("rst_num_ops", 32'(a_num_ops), 0);
    chk("rst_ula_a", 32'(a_ula_a), 0);
    chk("rst_ula_b", 32'(a_ula_b), 0);
    chk("rst_ula_sel", 32'(a_ula_sel), 0);
    chk("rst_res_dado", 32'(a_res_dado), 0);

    send_a(4'b0000, 8'd50, 8'd30, 1'b0);
    chk("soma_ula_a", 32'(a_ula_a), 50);
    chk("soma_ula_b", 32'(a_ula_b), 30);
    chk("soma_ula_sel", 32'(a_ula_sel), 0);
    chk("soma_valid_k", 32'(a_res_valid), 0);
    chk("soma_ready_k", 32'(a_cmd_ready), 0);
    tick();
    chk("soma_valid_k1", 32'(a_res_valid), 1);
    chk("soma_dado", 32'(a_res_dado), 80);
    chk("soma_flags", 32'(a_res_flags), 'b100);
    chk("soma_erro", 32'(a_res_erro), 0);
    chk("soma_acc", 32'(a_acc), 80);
    handshake_a();
    chk("soma_hs_valid", 32'(a_res_valid), 0);
    chk("soma_hs_ready", 32'(a_cmd_ready), 1);
    chk("soma_hs_num", 32'(a_num_ops), 1);

    send_a(4'b0010, 8'd20, 8'd20, 1'b0);
    tick();
    chk("mult_dado", 32'(a_res_dado), 400);
    chk("mult_flags", 32'(a_res_flags), 'b001);
    chk("mult_acc", 32'(a_acc), 144);
    handshake_a();
    send_a(4'b0001, 8'd7, 8'd44, 1'b1);
    chk("sub_acc_ula_a", 32'(a_ula_a), 144);
    tick();
    chk("sub_dado", 32'(a_res_dado), 100);
    chk("sub_acc", 32'(a_acc), 100);
    handshake_a();
    chk("sub_num", 32'(a_num_ops), 3);

    send_a(4'b0011, 8'd100, 8'd0, 1'b0);
    chk("div0_valid_k", 32'(a_res_valid), 1);
    tick();
    chk("div0_valid_k1", 32'(a_res_valid), 1);
    chk("div0_dado", 32'(a_res_dado), 'hFFFF);
    chk("div0_erro", 32'(a_res_erro), 1);
    chk("div0_flags", 32'(a_res_flags), 0);
    chk("div0_ula_sel", 32'(a_ula_sel), 'b0001);
    chk("div0_ula_a", 32'(a_ula_a), 144);
    chk("div0_acc", 32'(a_acc), 100);
    handshake_a();
    chk("div0_num", 32'(a_num_ops), 4);
    send_a(4'b0101, 8'd1, 8'd2, 1'b0);
    chk("badop_dado", 32'(a_res_dado), 0);
    chk("badop_erro", 32'(a_res_erro), 1);
    chk("badop_acc", 32'(a_acc), 100);
    handshake_a();

    send_a(4'b0100, 8'd23, 8'd5, 1'b0);
    tick();
    a_cmd_op = 4'b0000; a_cmd_a = 8'd9; a_cmd_b = 8'd9; a_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_dado", 32'(a_res_dado), 3);
      chk("hold_valid", 32'(a_res_valid), 1);
      chk("hold_cmd_ready", 32'(a_cmd_ready), 0);
      tick();
    end
    a_cmd_valid = 1'b0;
    chk("hold_acc", 32'(a_acc), 3);
    handshake_a();
    chk("resto_num", 32'(a_num_ops), 6);
    chk("resto_ready_after", 32'(a_cmd_ready), 1);
    chk("resto_acc_after", 32'(a_acc), 3);

    for (int i = 0; i < 9; i++) begin
      send_a(4'b0000, 8'd1, 8'd1, 1'b0);
      tick();
      handshake_a();
    end
    chk("wrap_num_15", 32'(a_num_ops), 15);
    chk("wrap_acc", 32'(a_acc), 2);
    send_a(4'b0000, 8'd1, 8'd1, 1'b0);
    tick();
    handshake_a();
    chk("wrap_num_0", 32'(a_num_ops), 0);

    bc_cmd_op = 4'b0000; bc_cmd_a = 8'd5; bc_cmd_b = 8'd9; bc_cmd_valid = 1'b1;
    tick();
    bc_cmd_valid = 1'b0; bc_cmd_a = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("l3_early_valid", 32'(b_res_valid), 0);
      chk("l4_early_valid", 32'(c_res_valid), 0);
      if (i < 2) tick();
    end
    tick();
    chk("l3_valid_k3", 32'(b_res_valid), 1);
    chk("l4_valid_k3", 32'(c_res_valid), 0);
    chk("l3_dado", 32'(b_res_dado), 14);
    chk("l3_flags", 32'(b_res_flags), 'b010);
    tick();
    chk("l4_valid_k4", 32'(c_res_valid), 1);
    chk("l4_dado", 32'(c_res_dado), 14);
    chk("l4_acc", 32'(c_acc), 14);
    bc_res_ready = 1'b1;
    tick();
    bc_res_ready = 1'b0;
    chk("l3_num", 32'(b_num_ops), 1);
    chk("l4_num", 32'(c_num_ops), 1);

    bc_cmd_op = 4'b0010; bc_cmd_a = 8'd3; bc_cmd_b = 8'd3; bc_cmd_valid = 1'b1;
    tick();
    bc_cmd_valid = 1'b0;
    chk("l4_busy", 32'(c_cmd_ready), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(c_res_valid), 0);
    chk("abort_ready", 32'(c_cmd_ready), 1);
    chk("abort_acc", 32'(c_acc), 0);
    chk("abort_num", 32'(c_num_ops), 0);
    tick(); tick(); tick();
    chk("abort_discard_l4", 32'(c_res_valid), 0);
    chk("abort_discard_l3", 32'(b_res_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
